// File: rtl/addsub_pkg.sv
// Shared types for the add/sub result buffer: entry layout and field offsets.
// With ADDSUB_ZERO_CHECK_EN defined, each entry carries an extra zero-flag check bit.
package addsub_pkg;

`ifdef ADDSUB_ZERO_CHECK_EN
  localparam int ENTRY_W = 36;

  typedef struct packed {
    logic [31:0] result;
    logic        c;
    logic        overflow;
    logic        zero;
    logic        zero_err;
  } addsub_entry_t;

  localparam int OFS_ZERO_ERR = 0;
  localparam int OFS_ZERO     = 1;
  localparam int OFS_OVERFLOW = 2;
  localparam int OFS_C        = 3;
  localparam int OFS_RESULT   = 4;
`else
  localparam int ENTRY_W = 35;

  typedef struct packed {
    logic [31:0] result;
    logic        c;
    logic        overflow;
    logic        zero;
  } addsub_entry_t;

  localparam int OFS_ZERO     = 0;
  localparam int OFS_OVERFLOW = 1;
  localparam int OFS_C        = 2;
  localparam int OFS_RESULT   = 3;
`endif

endpackage

// File: rtl/addsub_fifo.sv
// Generic synchronous FIFO with combinational head read; pointers wrap modulo DEPTH.
// A push when full or a pop when empty is ignored.
module addsub_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = cnt;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/addsub_result_buf.sv
// Buffers add/sub results and flags between two valid/ready handshakes; tracks overflow events.
// Build option ADDSUB_ZERO_CHECK_EN stores a zero-flag consistency bit per entry.
module addsub_result_buf
  import addsub_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_result,
  input  logic                   in_c,
  input  logic                   in_overflow,
  input  logic                   in_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic                   out_c,
  output logic                   out_overflow,
  output logic                   out_zero,
  output logic                   out_zero_err,
  output logic [$clog2(DEPTH):0] level,
  output logic                   sticky_ovf,
  input  logic                   sticky_clr,
  output logic [CNT_W-1:0]       ovf_cnt
);

  addsub_entry_t    wr_entry;
  addsub_entry_t    head;
  logic [ENTRY_W-1:0] rd_bits;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf_push;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ovf_push  = push && in_overflow;

  always_comb begin
    wr_entry          = '0;
    wr_entry.result   = in_result;
    wr_entry.c        = in_c;
    wr_entry.overflow = in_overflow;
    wr_entry.zero     = in_zero;
`ifdef ADDSUB_ZERO_CHECK_EN
    wr_entry.zero_err = (in_zero != ~|in_result);
`endif
  end

  addsub_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_bits),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Outputs read zero while empty so stale storage never leaks out.
  assign head         = rd_bits;
  assign out_result   = out_valid ? head.result   : '0;
  assign out_c        = out_valid & head.c;
  assign out_overflow = out_valid & head.overflow;
  assign out_zero     = out_valid & head.zero;
`ifdef ADDSUB_ZERO_CHECK_EN
  assign out_zero_err = out_valid & head.zero_err;
`else
  assign out_zero_err = 1'b0;
`endif

  // Overflow set wins over clear; counter restarts at 1 when both coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      if (ovf_push)        sticky_ovf <= 1'b1;
      else if (sticky_clr) sticky_ovf <= 1'b0;

      if (sticky_clr)
        ovf_cnt <= ovf_push ? CNT_W'(1) : '0;
      else if (ovf_push && (ovf_cnt != {CNT_W{1'b1}}))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_addsub_result_buf.sv
// Self-checking bench for addsub_result_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_addsub_result_buf;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_c;
  logic             in_overflow;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_c;
  logic             out_overflow;
  logic             out_zero;
  logic             out_zero_err;
  logic [2:0]       level;
  logic             sticky_ovf;
  logic             sticky_clr;
  logic [CNT_W-1:0] ovf_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: entries are {result, c, overflow, zero}.
  logic [34:0] q[$];
  logic        m_sticky;
  int          m_cnt;

  always #5 clk = ~clk;

  addsub_result_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_c         (in_c),
    .in_overflow  (in_overflow),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_c        (out_c),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_zero_err (out_zero_err),
    .level        (level),
    .sticky_ovf   (sticky_ovf),
    .sticky_clr   (sticky_clr),
    .ovf_cnt      (ovf_cnt)
  );

  // One clock edge: model consumes the same inputs the DUT sees, then outputs settle.
  task automatic cycle();
    bit push, pop, ovf;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_sticky = 1'b0;
      m_cnt    = 0;
    end else begin
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      ovf  = push && in_overflow;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({in_result, in_c, in_overflow, in_zero});
      if (ovf)             m_sticky = 1'b1;
      else if (sticky_clr) m_sticky = 1'b0;
      if (sticky_clr)            m_cnt = ovf ? 1 : 0;
      else if (ovf && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  function automatic logic [34:0] exp_head();
    return (q.size() > 0) ? q[0] : 35'd0;
  endfunction

  function automatic logic exp_zerr();
    logic [34:0] e;
    if (q.size() == 0) return 1'b0;
    e = q[0];
`ifdef ADDSUB_ZERO_CHECK_EN
    return e[0] != (e[34:3] == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_result = 0; in_c = 0; in_overflow = 0; in_zero = 0;
    out_ready = 0; sticky_clr = 0;
  endtask

  task automatic set_in(input logic [31:0] r, input logic c, input logic ov, input logic z);
    in_valid = 1; in_result = r; in_c = c; in_overflow = ov; in_zero = z;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; set_in(32'hDEAD, 1, 1, 1); out_ready = 1;
    cycle(); cycle();
    rst = 0; idle_inputs();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if ({level, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_ctl cyc %0d: got lvl=%0d ov=%b ir=%b want 0/0/1", i, level, out_valid, in_ready);
      end
      n_cmp++;
      if ({ovf_cnt, sticky_ovf, out_result, out_c, out_overflow, out_zero, out_zero_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_out cyc %0d: got cnt=%0d st=%b res=%h flags=%b%b%b%b want all 0",
                 i, ovf_cnt, sticky_ovf, out_result, out_c, out_overflow, out_zero, out_zero_err);
      end
    end
  endtask

  task automatic test_single();
    set_in(32'h5, 0, 0, 0);
    cycle();
    in_valid = 0;
    n_cmp++;
    if ({out_valid, out_result, level} !== {1'b1, 32'h5, 3'd1}) begin
      n_fail++;
      $display("FAIL single_push: got v=%b res=%h lvl=%0d want 1/5/1", out_valid, out_result, level);
    end
    out_ready = 1;
    cycle();
    out_ready = 0;
    n_cmp++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL single_pop: got v=%b lvl=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_fill_drain();
    out_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      set_in(i, 0, 0, 0);
      cycle();
    end
    n_cmp++;
    if ({level, in_ready} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_full: got lvl=%0d ir=%b want 4/0", level, in_ready);
    end
    set_in(32'd99, 1, 1, 1);
    cycle();
    in_valid = 0;
    n_cmp++;
    if ({level, ovf_cnt, sticky_ovf} !== {3'd4, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_drop: got lvl=%0d cnt=%0d st=%b want 4/0/0", level, ovf_cnt, sticky_ovf);
    end
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if ({out_valid, out_result} !== {1'b1, 32'(i)}) begin
        n_fail++;
        $display("FAIL drain_order %0d: got v=%b res=%h want 1/%h", i, out_valid, out_result, i);
      end
      cycle();
    end
    out_ready = 0;
    n_cmp++;
    if (level !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got lvl=%0d want 0", level);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) begin
      set_in(32'h100 + i, 0, 0, 0);
      cycle();
    end
    set_in(32'h777, 0, 0, 0);
    out_ready = 1;
    cycle();
    in_valid = 0; out_ready = 0;
    n_cmp++;
    if ({level, in_ready, out_result} !== {3'd3, 1'b1, 32'h101}) begin
      n_fail++;
      $display("FAIL full_pushpop: got lvl=%0d ir=%b head=%h want 3/1/101", level, in_ready, out_result);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 0;
    n_cmp++;
    if (level !== 3'd0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: got lvl=%0d want 0 (model %0d)", level, q.size());
    end
  endtask

  task automatic test_stream();
    logic [34:0] e;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      set_in($urandom, $urandom_range(0, 1), 0, $urandom_range(0, 1));
      cycle();
      e = exp_head();
      n_cmp++;
      if ({level, out_valid, out_result, out_c, out_zero} !== {3'd1, 1'b1, e[34:3], e[2], e[0]}) begin
        n_fail++;
        $display("FAIL stream %0d: got lvl=%0d v=%b res=%h c=%b z=%b want 1/1/%h/%b/%b",
                 i, level, out_valid, out_result, out_c, out_zero, e[34:3], e[2], e[0]);
      end
    end
    in_valid = 0;
    cycle();
    out_ready = 0;
  endtask

  task automatic test_overflow();
    out_ready = 1;
    sticky_clr = 1; in_valid = 0;
    cycle();
    sticky_clr = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h8000_0000 + i, 1, 1, 0);
      cycle();
    end
    in_valid = 0;
    n_cmp++;
    if ({ovf_cnt, sticky_ovf} !== {4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_count: got cnt=%0d st=%b want 3/1", ovf_cnt, sticky_ovf);
    end
    set_in(32'h7FFF_FFFF, 0, 1, 0); sticky_clr = 1;
    cycle();
    in_valid = 0; sticky_clr = 0;
    n_cmp++;
    if ({ovf_cnt, sticky_ovf} !== {4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_clr_set: got cnt=%0d st=%b want 1/1", ovf_cnt, sticky_ovf);
    end
    sticky_clr = 1;
    cycle();
    sticky_clr = 0;
    n_cmp++;
    if ({ovf_cnt, sticky_ovf} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_clr: got cnt=%0d st=%b want 0/0", ovf_cnt, sticky_ovf);
    end
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      set_in($urandom, 0, 1, 0);
      cycle();
    end
    in_valid = 0;
    cycle();
    n_cmp++;
    if (ovf_cnt !== CNT_W'(CNT_MAX)) begin
      n_fail++;
      $display("FAIL ovf_saturate: got cnt=%0d want %0d", ovf_cnt, CNT_MAX);
    end
    out_ready = 0;
  endtask

  task automatic test_zero_check();
    logic exp_err;
`ifdef ADDSUB_ZERO_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    set_in(32'h0, 0, 0, 0);
    cycle();
    set_in(32'h0, 0, 0, 1);
    cycle();
    in_valid = 0;
    n_cmp++;
    if ({out_valid, out_zero_err} !== {1'b1, exp_err}) begin
      n_fail++;
      $display("FAIL zero_err_bad: got v=%b err=%b want 1/%b", out_valid, out_zero_err, exp_err);
    end
    out_ready = 1;
    cycle();
    out_ready = 0;
    n_cmp++;
    if ({out_valid, out_zero_err} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_err_good: got v=%b err=%b want 1/0", out_valid, out_zero_err);
    end
    out_ready = 1;
    cycle();
    out_ready = 0;
  endtask

  task automatic test_random();
    logic [34:0] e;
    for (int i = 0; i < 400; i++) begin
      in_valid    = $urandom_range(0, 1);
      in_result   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      in_c        = $urandom_range(0, 1);
      in_overflow = ($urandom_range(0, 3) == 0);
      in_zero     = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 2) != 0);
      sticky_clr  = ($urandom_range(0, 15) == 0);
      rst         = (i == 200);
      cycle();
      e = exp_head();
      n_cmp++;
      if ({level, out_valid, in_ready} !== {3'(q.size()), q.size() > 0, q.size() < DEPTH}) begin
        n_fail++;
        $display("FAIL rnd_ctl cyc %0d: got lvl=%0d v=%b ir=%b want lvl=%0d", i, level, out_valid, in_ready, q.size());
      end
      n_cmp++;
      if ({out_result, out_c, out_overflow, out_zero, out_zero_err} !== {e, exp_zerr()}) begin
        n_fail++;
        $display("FAIL rnd_head cyc %0d: got %h %b%b%b%b want %h %b", i, out_result, out_c, out_overflow,
                 out_zero, out_zero_err, e, exp_zerr());
      end
      n_cmp++;
      if ({sticky_ovf, ovf_cnt} !== {m_sticky, CNT_W'(m_cnt)}) begin
        n_fail++;
        $display("FAIL rnd_ovf cyc %0d: got st=%b cnt=%0d want %b/%0d", i, sticky_ovf, ovf_cnt, m_sticky, m_cnt);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pushpop();
    test_stream();
    test_overflow();
    test_zero_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_result_buf.md
Name: addsub_result_buf

Overview:
- Capture/buffer stage directly downstream of the 32-bit add/sub unit.
- Accepts each combinational result with its carry, overflow and zero flags under a valid/ready handshake, and queues them in a small synchronous FIFO.
- Presents results to the consumer (display/regfile writeback) under a second valid/ready handshake.
- Maintains a sticky overflow flag and a saturating overflow-event counter for debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the overflow-event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  buffer can accept (not full).
- in_result  in  32  add/sub result.
- in_c  in  1  carry out.
- in_overflow  in  1  signed overflow.
- in_zero  in  1  zero flag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_result  out  32  head result.
- out_c  out  1  head carry.
- out_overflow  out  1  head overflow.
- out_zero  out  1  head zero.
- out_zero_err  out  1  head zero flag inconsistent with result (optional feature).
- level  out  $clog2(DEPTH)+1  current occupancy.
- sticky_ovf  out  1  set by any accepted entry with overflow.
- sticky_clr  in  1  clears sticky_ovf and ovf_cnt.
- ovf_cnt  out  CNT_W  number of accepted entries with overflow, saturating.

Behaviour:
- Clocking and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: level=0, out_valid=0, out_result=0, out_c/out_overflow/out_zero/out_zero_err=0, sticky_ovf=0, ovf_cnt=0, in_ready=1. Pointers return to 0.
- Reset mid-operation discards all queued entries. A push or pop requested in the reset cycle is ignored.
- Push: in_valid && in_ready at edge. Pop: out_valid && out_ready at edge.
- in_ready = (level != DEPTH), combinational from registered state only. There is no full-bypass: when full, in_ready=0 even if out_ready=1.
- out_valid = (level != 0). out_* are driven from the head entry, read combinationally from the storage array (no extra register).
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N.
- No combinational in->out path.
- Simultaneous push and pop when 0<level<DEPTH: level unchanged, both pointers advance.
- Simultaneous push and pop when level=0: pop is impossible; push only.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Order is strict FIFO.
- Flags are stored verbatim; the buffer performs no arithmetic on results.
- sticky_ovf: next = sticky_clr ? 0 : sticky_ovf. It is then set if a push with in_overflow=1 occurs; set wins over clear in the same cycle.
- ovf_cnt: a push with in_overflow=1 increments it, saturating at 2^CNT_W-1 with no wrap.
- With sticky_clr in the same cycle as such a push, ovf_cnt becomes 1; with sticky_clr alone, ovf_cnt becomes 0.
- in_* values when in_valid=0, or when in_ready=0, are ignored.

Optional Feature:
- Macro: ADDSUB_ZERO_CHECK_EN.
- Defined: at push, the stage computes chk = (in_zero != ~|in_result) and stores it with the entry. out_zero_err presents the head entry's chk, qualified by out_valid.
- Not defined: no chk storage; out_zero_err tied 0. The port is present in both builds.

Decomposition:
- Package addsub_pkg:
  - ENTRY_W=35 (36 with the check bit).
  - Packed struct addsub_entry_t {result[31:0], c, overflow, zero [, zero_err]}.
  - Field-offset constants.
- One sub-module, addsub_fifo: generic synchronous FIFO (WIDTH, DEPTH; push/pop/level/full/empty).
- The top adds the handshake wiring, the sticky flag and the counter.

Test Plan:
- Reset then idle: level=0, out_valid=0, in_ready=1, ovf_cnt=0 for 5 cycles.
- Push 0x00000005/c0/ov0/z0 with out_ready=0 -> next cycle out_valid=1, out_result=0x5, level=1. Assert out_ready -> level=0, out_valid=0.
- Push 4 entries (1,2,3,4) with out_ready=0 -> level=4, in_ready=0. A fifth push with in_valid=1 is dropped. Drain -> outputs 1,2,3,4 in order.
- Full, then push and pop in the same cycle -> pop accepted, push refused (in_ready=0), level=3.
- Continuous streaming with in_valid=out_ready=1 for 20 cycles (pointer wrap) -> output sequence matches input, level stays 1.
- Push overflow entries 3 times -> ovf_cnt=3, sticky_ovf=1. sticky_clr with a simultaneous overflow push -> sticky_ovf=1, ovf_cnt=1.
- With ADDSUB_ZERO_CHECK_EN: push result=0x0 with zero=0 -> out_zero_err=1.
